// File: rtl/irq_ctrl_pkg.sv
// Shared types and defaults for the interrupt arbiter.
// FSM encodings plus default source count and holdoff length.
package irq_ctrl_pkg;

    localparam int DEF_NUM_SRC        = 4;
    localparam int DEF_HOLDOFF_CYCLES = 4;
    localparam int HOLD_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

endpackage

// File: rtl/irq_arbiter_if.sv
// Interrupt bus between the event sources / CPU and the arbiter.
// The master side drives events, masks and acks; the arbiter is the slave.
interface irq_arbiter_if
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC
);
    localparam int ID_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] irq_pulse_in;
    logic [NUM_SRC-1:0] irq_enable;
    logic               irq_ack;
    logic [NUM_SRC-1:0] ovf_clr;
    logic               irq_out;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_SRC-1:0] irq_pending;
    logic [NUM_SRC-1:0] irq_overflow;

    modport master (
        output irq_pulse_in, irq_enable, irq_ack, ovf_clr,
        input  irq_out, irq_id, irq_pending, irq_overflow
    );

    modport slave (
        input  irq_pulse_in, irq_enable, irq_ack, ovf_clr,
        output irq_out, irq_id, irq_pending, irq_overflow
    );

endinterface

// File: rtl/irq_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NUM_SRC.
module irq_rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req_i,
    input  logic [$clog2(NUM_SRC)-1:0] ptr_i,
    output logic [$clog2(NUM_SRC)-1:0] id_o,
    output logic                       vld_o
);
    localparam int ID_W = $clog2(NUM_SRC);

    int idx;

    always_comb begin
        id_o  = '0;
        vld_o = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_SRC; off++) begin
            idx = (int'(ptr_i) + off) % NUM_SRC;
            if (!vld_o && req_i[idx]) begin
                vld_o = 1'b1;
                id_o  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches event pulses, presents one enabled source at a
// time round-robin, and enforces an idle gap after each acknowledge.
module irq_arbiter
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC        = DEF_NUM_SRC,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    irq_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_SRC);

    typedef logic [NUM_SRC-1:0] vec_t;

    state_e            state_q, state_d;
    vec_t              pend_q, pend_d;
    vec_t              ovf_q, ovf_d;
    vec_t              clr;
    logic              out_q, out_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_vld;
    vec_t              req;
    logic              ack_hit;

    assign req     = pend_q & bus.irq_enable;
    assign ack_hit = (state_q == ST_ACTIVE) && bus.irq_ack;

    irq_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .id_o  (gnt_id),
        .vld_o (gnt_vld)
    );

    // A new pulse always wins over the ack-clear of the same bit.
    always_comb begin
        clr = '0;
        if (ack_hit) clr[id_q] = 1'b1;
        pend_d = (pend_q & ~clr) | bus.irq_pulse_in;
        ovf_d  = (ovf_q & ~bus.ovf_clr)
               | (bus.irq_pulse_in & pend_q & ~clr);
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    id_d    = gnt_id;
                    out_d   = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.irq_ack) begin
                    out_d = 1'b0;
                    ptr_d = (id_q == ID_W'(NUM_SRC - 1))
                          ? '0 : id_q + ID_W'(1);
                    if (HOLDOFF_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLD_W'(HOLDOFF_CYCLES);
                    end
                end
            end
            ST_HOLDOFF: begin
                cnt_d = cnt_q - HOLD_W'(1);
                if (cnt_q <= HOLD_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ovf_q   <= '0;
            out_q   <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.irq_out      = out_q;
    assign bus.irq_id       = id_q;
    assign bus.irq_pending  = pend_q;
    assign bus.irq_overflow = ovf_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: grant latency, holdoff, round-robin,
// masking, overflow, ack/pulse collision and asynchronous reset.
module tb_irq_arbiter;
    localparam int N = 4;
    localparam int H = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    irq_arbiter_if #(.NUM_SRC(N)) bus ();

    irq_arbiter #(
        .NUM_SRC        (N),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        bus.irq_pulse_in = v;
        tick();
        bus.irq_pulse_in = '0;
    endtask

    task automatic ack_and_settle();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        repeat (H) tick();
    endtask

    task automatic wait_irq(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.irq_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.irq_out !== 1'b0 || bus.irq_id !== 2'd0 ||
            bus.irq_pending !== 4'h0 || bus.irq_overflow !== 4'h0) begin
            errors++;
            $display("FAIL reset: out=%b id=%0d pend=%b ovf=%b, want 0 0 0000 0000",
                     bus.irq_out, bus.irq_id, bus.irq_pending, bus.irq_overflow);
        end
    endtask

    task automatic test_single();
        pulse(4'b0100);
        checks++;
        if (bus.irq_pending !== 4'b0100 || bus.irq_out !== 1'b0) begin
            errors++;
            $display("FAIL single_pend: pend=%b out=%b, want 0100 0",
                     bus.irq_pending, bus.irq_out);
        end
        tick();
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd2) begin
            errors++;
            $display("FAIL single_grant: out=%b id=%0d, want 1 2",
                     bus.irq_out, bus.irq_id);
        end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        checks++;
        if (bus.irq_out !== 1'b0 || bus.irq_pending !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack: out=%b pend=%b, want 0 0000",
                     bus.irq_out, bus.irq_pending);
        end
        pulse(4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.irq_out !== 1'b0) begin
                errors++;
                $display("FAIL holdoff_gap[%0d]: out=%b, want 0", i, bus.irq_out);
            end
        end
        tick();
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd0) begin
            errors++;
            $display("FAIL holdoff_end: out=%b id=%0d, want 1 0",
                     bus.irq_out, bus.irq_id);
        end
        ack_and_settle();
    endtask

    task automatic test_fairness();
        logic ok;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            pulse(4'b1111);
            for (int k = 0; k < N; k++) begin
                wait_irq(ok);
                checks++;
                if (!ok || bus.irq_id !== 2'(k)) begin
                    errors++;
                    $display("FAIL fair_r%0d_k%0d: ok=%b id=%0d, want 1 %0d",
                             r, k, ok, bus.irq_id, k);
                end
                ack_and_settle();
            end
        end
        checks++;
        if (bus.irq_pending !== 4'h0) begin
            errors++;
            $display("FAIL fair_drain: pend=%b, want 0000", bus.irq_pending);
        end
    endtask

    task automatic test_mask();
        bus.irq_enable = 4'b1101;
        pulse(4'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.irq_out !== 1'b0) begin
                errors++;
                $display("FAIL mask_hold[%0d]: out=%b, want 0", i, bus.irq_out);
            end
        end
        checks++;
        if (bus.irq_pending !== 4'b0010) begin
            errors++;
            $display("FAIL mask_pend: pend=%b, want 0010", bus.irq_pending);
        end
        bus.irq_enable = 4'b1111;
        tick();
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd1) begin
            errors++;
            $display("FAIL mask_grant: out=%b id=%0d, want 1 1",
                     bus.irq_out, bus.irq_id);
        end
        ack_and_settle();
    endtask

    task automatic test_overflow();
        pulse(4'b1000);
        checks++;
        if (bus.irq_overflow !== 4'h0) begin
            errors++;
            $display("FAIL ovf_first: ovf=%b, want 0000", bus.irq_overflow);
        end
        pulse(4'b1000);
        checks++;
        if (bus.irq_overflow !== 4'b1000 || bus.irq_out !== 1'b1 ||
            bus.irq_id !== 2'd3) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b out=%b id=%0d, want 1000 1 3",
                     bus.irq_overflow, bus.irq_out, bus.irq_id);
        end
        bus.ovf_clr = 4'b1000;
        tick();
        bus.ovf_clr = '0;
        checks++;
        if (bus.irq_overflow !== 4'h0) begin
            errors++;
            $display("FAIL ovf_clr: ovf=%b, want 0000", bus.irq_overflow);
        end
        bus.ovf_clr = 4'b1000;
        pulse(4'b1000);
        bus.ovf_clr = '0;
        checks++;
        if (bus.irq_overflow !== 4'b1000) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b, want 1000", bus.irq_overflow);
        end
        bus.ovf_clr = 4'b1000;
        tick();
        bus.ovf_clr = '0;
        ack_and_settle();
        checks++;
        if (bus.irq_pending !== 4'h0 || bus.irq_overflow !== 4'h0) begin
            errors++;
            $display("FAIL ovf_drain: pend=%b ovf=%b, want 0000 0000",
                     bus.irq_pending, bus.irq_overflow);
        end
    endtask

    task automatic test_collision();
        pulse(4'b0001);
        tick();
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd0) begin
            errors++;
            $display("FAIL coll_grant: out=%b id=%0d, want 1 0",
                     bus.irq_out, bus.irq_id);
        end
        bus.irq_ack = 1'b1;
        pulse(4'b0001);
        bus.irq_ack = 1'b0;
        checks++;
        if (bus.irq_out !== 1'b0 || bus.irq_pending !== 4'b0001 ||
            bus.irq_overflow !== 4'h0) begin
            errors++;
            $display("FAIL coll_keep: out=%b pend=%b ovf=%b, want 0 0001 0000",
                     bus.irq_out, bus.irq_pending, bus.irq_overflow);
        end
        for (int i = 0; i < H; i++) begin
            tick();
            checks++;
            if (bus.irq_out !== 1'b0) begin
                errors++;
                $display("FAIL coll_gap[%0d]: out=%b, want 0", i, bus.irq_out);
            end
        end
        tick();
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd0) begin
            errors++;
            $display("FAIL coll_regrant: out=%b id=%0d, want 1 0",
                     bus.irq_out, bus.irq_id);
        end
        ack_and_settle();
    endtask

    task automatic test_reset_active();
        pulse(4'b0110);
        tick();
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd1) begin
            errors++;
            $display("FAIL rst_pre: out=%b id=%0d, want 1 1",
                     bus.irq_out, bus.irq_id);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.irq_out !== 1'b0 || bus.irq_id !== 2'd0 ||
            bus.irq_pending !== 4'h0 || bus.irq_overflow !== 4'h0) begin
            errors++;
            $display("FAIL rst_async: out=%b id=%0d pend=%b ovf=%b, want 0 0 0000 0000",
                     bus.irq_out, bus.irq_id, bus.irq_pending, bus.irq_overflow);
        end
        bus.irq_pulse_in = 4'b0001;
        bus.irq_ack      = 1'b1;
        tick();
        rst              = 1'b0;
        bus.irq_pulse_in = '0;
        tick();
        bus.irq_ack = 1'b0;
        checks++;
        if (bus.irq_out !== 1'b0 || bus.irq_pending !== 4'h0) begin
            errors++;
            $display("FAIL rst_stray: out=%b pend=%b, want 0 0000",
                     bus.irq_out, bus.irq_pending);
        end
        pulse(4'b0100);
        tick();
        checks++;
        if (bus.irq_out !== 1'b1 || bus.irq_id !== 2'd2) begin
            errors++;
            $display("FAIL rst_after: out=%b id=%0d, want 1 2",
                     bus.irq_out, bus.irq_id);
        end
        ack_and_settle();
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.irq_pulse_in = '0;
        bus.irq_enable   = '1;
        bus.irq_ack      = 1'b0;
        bus.ovf_clr      = '0;
        test_reset();
        test_single();
        test_fairness();
        test_mask();
        test_overflow();
        test_collision();
        test_reset_active();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
